// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_pkg
// Description : Shared constants, FSM encoding and width helper for the
//               truth-table sweep checker.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_pkg;

    localparam int c_MAX_N_IN   = 8;
    localparam int c_MAX_SETTLE = 15;
    localparam int c_TMR_W      = 4;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

    // One extra bit so a sweep where every vector fails (2^N) still fits.
    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tt_settle_timer
// Description : Settle-time counter; tc marks the last hold cycle of a vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    if (SETTLE == 0) begin : g_no_wait
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst_n, clr, en};
        assign tc       = 1'b1;
    end else begin : g_count
        logic [c_TMR_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (clr) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= r_cnt + c_TMR_W'(1);
            end
        end

        assign tc = (r_cnt == c_TMR_W'(SETTLE - 1));
    end

endmodule
`default_nettype wire

// File: rtl/tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_checker
// Description : Sweeps all 2^N_IN input vectors into two implementations and
//               checks both outputs against a latched golden truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2,
    parameter int CNT_W  = cnt_w(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   golden,
    output logic [N_IN-1:0]      vec_o,
    output logic                 vec_valid,
    input  logic                 dut_a,
    input  logic                 dut_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [1:0]           fail_mask,
    output logic [N_IN-1:0]      first_fail,
    output logic                 first_fail_valid
);

    localparam logic [N_IN-1:0] c_VEC_LAST = '1;

    if (N_IN < 1 || N_IN > c_MAX_N_IN || SETTLE < 0 || SETTLE > c_MAX_SETTLE ||
        CNT_W != cnt_w(N_IN)) begin : g_param_err
        $error("tt_sweep_checker: illegal N_IN/SETTLE/CNT_W combination");
    end

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [2**N_IN-1:0]  r_golden;
    logic                w_tmr_clr;
    logic                w_tmr_en;
    logic                w_tc;
    logic                w_expected;
    logic                w_mis_a;
    logic                w_mis_b;
    logic                w_mis_any;
    logic [CNT_W-1:0]    w_err_next;

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_tmr_clr),
        .en    (w_tmr_en),
        .tc    (w_tc)
    );

    assign w_expected = r_golden[vec_o];
    assign w_mis_a    = dut_a ^ w_expected;
    assign w_mis_b    = dut_b ^ w_expected;
    assign w_mis_any  = w_mis_a | w_mis_b;
    assign w_err_next = err_count + CNT_W'(w_mis_any);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = (SETTLE == 0) ? c_ST_SAMPLE : c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (w_tc) begin
                    w_state_next = c_ST_SAMPLE;
                end
            end
            c_ST_SAMPLE: begin
                if (vec_o == c_VEC_LAST) begin
                    w_state_next = c_ST_FINISH;
                end else begin
                    w_state_next = (SETTLE == 0) ? c_ST_SAMPLE : c_ST_HOLD;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        done      = 1'b0;
        w_tmr_en  = 1'b0;
        w_tmr_clr = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_tmr_clr = start;
            c_ST_HOLD:   w_tmr_en  = 1'b1;
            c_ST_SAMPLE: w_tmr_clr = 1'b1;
            default:     done      = 1'b1;
        endcase
    end

    // Result registers update on the last sample so they are already final
    // during the FINISH cycle and then hold until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_golden         <= '0;
            vec_o            <= '0;
            vec_valid        <= 1'b0;
            busy             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            fail_mask        <= 2'b00;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_golden         <= golden;
                        vec_o            <= '0;
                        vec_valid        <= 1'b1;
                        busy             <= 1'b1;
                        err_count        <= '0;
                        fail_mask        <= 2'b00;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                c_ST_SAMPLE: begin
                    err_count <= w_err_next;
                    fail_mask <= fail_mask | {w_mis_b, w_mis_a};
                    if (w_mis_any && !first_fail_valid) begin
                        first_fail       <= vec_o;
                        first_fail_valid <= 1'b1;
                    end
                    if (vec_o == c_VEC_LAST) begin
                        vec_o     <= '0;
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                        pass      <= (w_err_next == '0);
                    end else begin
                        vec_o <= vec_o + N_IN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep_checker
// Description : Self-checking bench: vector table, random faults vs. a
//               reference model, plus restart/golden-change/abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_checker;

    typedef struct {
        logic [15:0] golden;
        logic [15:0] flip_a;
        logic [15:0] flip_b;
        int          err;
        logic [1:0]  mask;
        int          first;
        logic        ffv;
        logic        pass;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] golden;
    logic [3:0]  vec_o;
    logic        vec_valid;
    logic        dut_a;
    logic        dut_b;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [1:0]  fail_mask;
    logic [3:0]  first_fail;
    logic        first_fail_valid;

    logic        start3;
    logic [7:0]  golden3;
    logic [2:0]  vec3;
    logic        valid3;
    logic        a3;
    logic        b3;
    logic        busy3;
    logic        done3;
    logic        pass3;
    logic [3:0]  err3;
    logic [1:0]  mask3;
    logic [2:0]  first3;
    logic        ffv3;

    // Behaviour of the two implementations: fn is the realised function,
    // fa/fb mark vectors where each implementation is faulty.
    logic [15:0] fn;
    logic [15:0] fa;
    logic [15:0] fb;
    logic [7:0]  fn3;
    logic        junk;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t tbl[10];

    always #5 clk = ~clk;

    always @(negedge clk) junk <= 1'($urandom_range(1));

    assign dut_a = vec_valid ? (fn[vec_o] ^ fa[vec_o]) : junk;
    assign dut_b = vec_valid ? (fn[vec_o] ^ fb[vec_o]) : ~junk;
    assign a3    = valid3 ? fn3[vec3] : junk;
    assign b3    = valid3 ? fn3[vec3] : junk;

    tt_sweep_checker #(
        .N_IN   (4),
        .SETTLE (2)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .golden           (golden),
        .vec_o            (vec_o),
        .vec_valid        (vec_valid),
        .dut_a            (dut_a),
        .dut_b            (dut_b),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .fail_mask        (fail_mask),
        .first_fail       (first_fail),
        .first_fail_valid (first_fail_valid)
    );

    tt_sweep_checker #(
        .N_IN   (3),
        .SETTLE (0)
    ) u_dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start3),
        .golden           (golden3),
        .vec_o            (vec3),
        .vec_valid        (valid3),
        .dut_a            (a3),
        .dut_b            (b3),
        .busy             (busy3),
        .done             (done3),
        .pass             (pass3),
        .err_count        (err3),
        .fail_mask        (mask3),
        .first_fail       (first3),
        .first_fail_valid (ffv3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk every vector, decide what each implementation outputs
    // and compare that against the truth table.
    function automatic vec_t model(input logic [15:0] g, input logic [15:0] f_a,
                                   input logic [15:0] f_b);
        vec_t r;
        r.golden = g;
        r.flip_a = f_a;
        r.flip_b = f_b;
        r.err    = 0;
        r.mask   = 2'b00;
        r.first  = 0;
        r.ffv    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bit out_a, out_b, bad_a, bad_b;
            out_a = g[k] ^ f_a[k];
            out_b = g[k] ^ f_b[k];
            bad_a = (out_a != g[k]);
            bad_b = (out_b != g[k]);
            if (bad_a || bad_b) begin
                r.err++;
                if (!r.ffv) begin
                    r.first = k;
                    r.ffv   = 1'b1;
                end
            end
            if (bad_a) r.mask[0] = 1'b1;
            if (bad_b) r.mask[1] = 1'b1;
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    task automatic run(input vec_t v, input bit inject, input string tag);
        int lat;
        bit seen;
        golden = v.golden;
        fn     = v.golden;
        fa     = v.flip_a;
        fb     = v.flip_b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        seen   = 1'b0;
        while (lat < 300) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (inject) begin
                start = (lat == 5 || lat == 20);
                if (lat == 10) golden = 16'hFFFF;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, int'(seen), 1);
        if (!seen) return;
        chk({tag, "_latency"}, lat, 48);
        chk({tag, "_pass"}, int'(pass), int'(v.pass));
        chk({tag, "_err_count"}, int'(err_count), v.err);
        chk({tag, "_fail_mask"}, int'(fail_mask), int'(v.mask));
        chk({tag, "_first_fail"}, int'(first_fail), v.first);
        chk({tag, "_first_fail_valid"}, int'(first_fail_valid), int'(v.ffv));
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        chk({tag, "_valid_at_done"}, int'(vec_valid), 0);
        chk({tag, "_vec_at_done"}, int'(vec_o), 0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_err_held"}, int'(err_count), v.err);
    endtask

    initial begin
        int lat;
        int n_done;
        bit seen;

        rst_n   = 1'b0;
        start   = 1'b0;
        start3  = 1'b0;
        golden  = 16'h0;
        golden3 = 8'h0;
        fn      = 16'h0;
        fa      = 16'h0;
        fb      = 16'h0;
        fn3     = 8'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(vec_valid), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_pass", int'(pass), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_done", int'(done), 0);

        tbl[0] = '{16'h00F0, 16'h0000, 16'h0000, 0,  2'b00, 0,  1'b0, 1'b1};
        tbl[1] = '{16'h00F0, 16'h0000, 16'h00F0, 4,  2'b10, 4,  1'b1, 1'b0};
        tbl[2] = '{16'h00F0, 16'hFFFF, 16'h0000, 16, 2'b01, 0,  1'b1, 1'b0};
        tbl[3] = '{16'h0000, 16'h8000, 16'h0000, 1,  2'b01, 15, 1'b1, 1'b0};
        tbl[4] = '{16'hA5C3, 16'hFFFF, 16'hFFFF, 16, 2'b11, 0,  1'b1, 1'b0};
        for (int i = 5; i < 10; i++) begin
            logic [15:0] g, f_a, f_b;
            g   = 16'($urandom);
            f_a = 16'($urandom & $urandom & $urandom);
            f_b = (i == 7) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            tbl[i] = model(g, f_a, f_b);
        end

        for (int i = 0; i < 10; i++) begin
            run(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        run(tbl[0], 1'b1, "restart_ignored");

        // Abort: reset low mid-run while errors are accumulating.
        golden = 16'h00F0;
        fn     = 16'h00F0;
        fa     = 16'hFFFF;
        fb     = 16'h0000;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(vec_valid), 0);
        chk("abort_vec", int'(vec_o), 0);
        chk("abort_err", int'(err_count), 0);
        chk("abort_mask", int'(fail_mask), 0);
        chk("abort_first", int'(first_fail), 0);
        chk("abort_ffv", int'(first_fail_valid), 0);
        chk("abort_pass", int'(pass), 0);
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run(tbl[1], 1'b0, "after_abort");

        // Smallest-latency configuration: no settle cycles, 3 inputs.
        golden3 = 8'h96;
        fn3     = 8'h96;
        start3  = 1'b1;
        @(negedge clk);
        start3  = 1'b0;
        lat     = 0;
        seen    = 1'b0;
        while (lat < 100) begin
            if (done3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk("s0_done_seen", int'(seen), 1);
        chk("s0_latency", lat, 8);
        chk("s0_pass", int'(pass3), 1);
        chk("s0_err", int'(err3), 0);
        chk("s0_mask", int'(mask3), 0);
        chk("s0_ffv", int'(ffv3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
